// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one single-port synchronous RAM between requesters A and B.
// Latency: grant is combinational in cycle N, RAM command in N+1, read data and rvalid in N+3.
// Backpressure: x_gnt is the ready of each requester; stall masks new grants while in-flight ops drain.
module ram_port_arbiter #(
   parameter int DW    = 8,
   parameter int AW    = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [DW-1:0]    a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [DW-1:0]    a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [AW-1:0]    b_addr,
   input  logic [DW-1:0]    b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [DW-1:0]    b_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output logic [CNT_W-1:0] contention_cnt
);

   typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

   sel_t             r_last;
   logic             w_a_gnt;
   logic             w_b_gnt;
   logic             w_any_gnt;
   logic             w_sel_we;
   logic [AW-1:0]    w_sel_addr;
   logic [DW-1:0]    w_sel_wdata;
   logic             w_contend;

   logic             r_mem_en;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;

   logic             r_tag0_vld;
   sel_t             r_tag0_id;
   logic             r_tag1_vld;
   sel_t             r_tag1_id;

   logic             r_a_rvalid;
   logic             r_b_rvalid;
   logic [DW-1:0]    r_a_rdata;
   logic [DW-1:0]    r_b_rdata;
   logic [CNT_W-1:0] r_cnt;

   // Grant and winner mux: a tie goes to the side that did not win last; reset forces grants off
   always_comb begin
      w_a_gnt     = a_req & ~stall & ~rst & (~b_req | (r_last == SEL_B));
      w_b_gnt     = b_req & ~stall & ~rst & (~a_req | (r_last == SEL_A));
      w_any_gnt   = w_a_gnt | w_b_gnt;
      w_sel_we    = w_b_gnt ? b_we    : a_we;
      w_sel_addr  = w_b_gnt ? b_addr  : a_addr;
      w_sel_wdata = w_b_gnt ? b_wdata : a_wdata;
      w_contend   = a_req & b_req & ~stall;
   end

   // Round-robin pointer: remember the most recent winner, hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= SEL_B;
      end else if (w_a_gnt) begin
         r_last <= SEL_A;
      end else if (w_b_gnt) begin
         r_last <= SEL_B;
      end
   end

   // Command stage: register the winner's command; address/data hold when no grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_any_gnt;
         r_mem_we <= w_any_gnt & w_sel_we;
         if (w_any_gnt) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end
      end
   end

   // Read tag pipeline: stage 0 lines up with the RAM command, stage 1 with mem_rdata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag0_vld <= 1'b0;
         r_tag0_id  <= SEL_A;
         r_tag1_vld <= 1'b0;
         r_tag1_id  <= SEL_A;
      end else begin
         r_tag0_vld <= w_any_gnt & ~w_sel_we;
         r_tag0_id  <= w_b_gnt ? SEL_B : SEL_A;
         r_tag1_vld <= r_tag0_vld;
         r_tag1_id  <= r_tag0_id;
      end
   end

   // Response stage: capture RAM data for the tagged requester; rdata holds otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= r_tag1_vld & (r_tag1_id == SEL_A);
         r_b_rvalid <= r_tag1_vld & (r_tag1_id == SEL_B);
         if (r_tag1_vld && (r_tag1_id == SEL_A)) begin
            r_a_rdata <= mem_rdata;
         end
         if (r_tag1_vld && (r_tag1_id == SEL_B)) begin
            r_b_rdata <= mem_rdata;
         end
      end
   end

   // Contention counter: counts unstalled cycles with both requesting, sticks at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_contend && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign a_gnt          = w_a_gnt;
   assign b_gnt          = w_b_gnt;
   assign a_rvalid       = r_a_rvalid;
   assign b_rvalid       = r_b_rvalid;
   assign a_rdata        = r_a_rdata;
   assign b_rdata        = r_b_rdata;
   assign mem_en         = r_mem_en;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus against a cycle-scheduled reference model of the arbiter.
// Latency: model schedules RAM commands at grant+1 and read responses at grant+3.
// Backpressure: stall and simultaneous requests exercise grant masking and alternation.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall;
   logic       a_req, a_we, b_req, b_we;
   logic [5:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   logic [7:0] mem_rdata;

   // index 0: default CNT_W=16 instance, index 1: CNT_W=4 instance (same stimulus)
   wire  [1:0]      a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, mem_en_o, mem_we_o;
   wire  [1:0][7:0] a_rdata_o, b_rdata_o, mem_wdata_o;
   wire  [1:0][5:0] mem_addr_o;
   wire  [15:0]     cnt0;
   wire  [3:0]      cnt1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DW(8), .AW(6), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt_o[0]), .a_rvalid(a_rvalid_o[0]), .a_rdata(a_rdata_o[0]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt_o[0]), .b_rvalid(b_rvalid_o[0]), .b_rdata(b_rdata_o[0]),
      .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .contention_cnt(cnt0)
   );

   ram_port_arbiter #(.DW(8), .AW(6), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt_o[1]), .a_rvalid(a_rvalid_o[1]), .a_rdata(a_rdata_o[1]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt_o[1]), .b_rvalid(b_rvalid_o[1]), .b_rdata(b_rdata_o[1]),
      .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .contention_cnt(cnt1)
   );

   function automatic logic [7:0] init_val(int i);
      return 8'(i * 7 + 3);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural RAM: 1-cycle read latency, contents restored while reset is held
   logic [7:0] ram [64];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
         mem_rdata <= 8'h00;
      end else if (mem_en_o[0]) begin
         if (mem_we_o[0]) ram[mem_addr_o[0]] <= mem_wdata_o[0];
         else             mem_rdata <= ram[mem_addr_o[0]];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wd;
   } cmd_t;

   cmd_t       cmd_q [int];     // RAM command expected in a given cycle
   logic [7:0] rv_a  [int];     // A read data expected with rvalid in a given cycle
   logic [7:0] rv_b  [int];
   logic [7:0] ref_mem [64];    // contents as seen in grant order
   bit         m_last_b;
   int         m_cnt16, m_cnt4;
   logic [5:0] h_addr;
   logic [7:0] h_wd, h_ra, h_rb;

   initial begin
      bit         eg_a, eg_b, e_en, e_we, e_rva, e_rvb;
      cmd_t       c;
      forever begin
         @(negedge clk);
         if (rst) begin
            cmd_q.delete(); rv_a.delete(); rv_b.delete();
            for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
            m_last_b = 1'b1; m_cnt16 = 0; m_cnt4 = 0;
            h_addr = '0; h_wd = '0; h_ra = '0; h_rb = '0;
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("rst_a_gnt%0d", k), a_gnt_o[k], 0);
               chk($sformatf("rst_b_gnt%0d", k), b_gnt_o[k], 0);
               chk($sformatf("rst_mem_en%0d", k), mem_en_o[k], 0);
               chk($sformatf("rst_mem_we%0d", k), mem_we_o[k], 0);
               chk($sformatf("rst_mem_addr%0d", k), mem_addr_o[k], 0);
               chk($sformatf("rst_mem_wdata%0d", k), mem_wdata_o[k], 0);
               chk($sformatf("rst_a_rvalid%0d", k), a_rvalid_o[k], 0);
               chk($sformatf("rst_b_rvalid%0d", k), b_rvalid_o[k], 0);
               chk($sformatf("rst_a_rdata%0d", k), a_rdata_o[k], 0);
               chk($sformatf("rst_b_rdata%0d", k), b_rdata_o[k], 0);
            end
            chk("rst_cnt16", cnt0, 0);
            chk("rst_cnt4", cnt1, 0);
         end else begin
            eg_a = a_req && !stall && (!b_req || m_last_b);
            eg_b = b_req && !stall && (!a_req || !m_last_b);
            e_en = cmd_q.exists(cyc);
            e_we = 1'b0;
            if (e_en) begin
               e_we   = cmd_q[cyc].we;
               h_addr = cmd_q[cyc].addr;
               h_wd   = cmd_q[cyc].wd;
               cmd_q.delete(cyc);
            end
            e_rva = rv_a.exists(cyc);
            if (e_rva) begin h_ra = rv_a[cyc]; rv_a.delete(cyc); end
            e_rvb = rv_b.exists(cyc);
            if (e_rvb) begin h_rb = rv_b[cyc]; rv_b.delete(cyc); end
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("a_gnt%0d", k), a_gnt_o[k], eg_a);
               chk($sformatf("b_gnt%0d", k), b_gnt_o[k], eg_b);
               chk($sformatf("mem_en%0d", k), mem_en_o[k], e_en);
               chk($sformatf("mem_we%0d", k), mem_we_o[k], e_we);
               chk($sformatf("mem_addr%0d", k), mem_addr_o[k], h_addr);
               chk($sformatf("mem_wdata%0d", k), mem_wdata_o[k], h_wd);
               chk($sformatf("a_rvalid%0d", k), a_rvalid_o[k], e_rva);
               chk($sformatf("b_rvalid%0d", k), b_rvalid_o[k], e_rvb);
               chk($sformatf("a_rdata%0d", k), a_rdata_o[k], h_ra);
               chk($sformatf("b_rdata%0d", k), b_rdata_o[k], h_rb);
            end
            chk("cnt16", cnt0, m_cnt16);
            chk("cnt4", cnt1, m_cnt4);
            // advance the model by this cycle's events
            if (a_req && b_req && !stall) begin
               if (m_cnt16 < 65535) m_cnt16++;
               if (m_cnt4 < 15)     m_cnt4++;
            end
            if (eg_a || eg_b) begin
               c.we   = eg_a ? a_we    : b_we;
               c.addr = eg_a ? a_addr  : b_addr;
               c.wd   = eg_a ? a_wdata : b_wdata;
               cmd_q[cyc + 1] = c;
               if (c.we)      ref_mem[c.addr] = c.wd;
               else if (eg_a) rv_a[cyc + 3] = ref_mem[c.addr];
               else           rv_b[cyc + 3] = ref_mem[c.addr];
               m_last_b = eg_b;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick(); tick();

      // 1: lone A write, command appears the following cycle, no response
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 8'hA5;
      #3 chk("t1_a_gnt", a_gnt_o[0], 1);
      tick();
      a_req = 1'b0;
      #3;
      chk("t1_mem_en", mem_en_o[0], 1);
      chk("t1_mem_we", mem_we_o[0], 1);
      chk("t1_mem_addr", mem_addr_o[0], 32'h05);
      chk("t1_mem_wdata", mem_wdata_o[0], 32'hA5);
      chk("t1_a_rvalid", a_rvalid_o[0], 0);
      repeat (4) tick();

      // lone B write so the pointer points at B before the tie test
      b_req = 1'b1; b_we = 1'b1; b_addr = 6'h06; b_wdata = 8'h66;
      #3 chk("pre2_b_gnt", b_gnt_o[0], 1);
      tick();
      b_req = 1'b0;
      tick(); tick();

      // 2: both read for 4 cycles, grants alternate starting with A
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'h06;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk($sformatf("t2_a_gnt_%0d", i), a_gnt_o[0], (i % 2) == 0);
         chk($sformatf("t2_b_gnt_%0d", i), b_gnt_o[0], (i % 2) == 1);
         tick();
      end
      a_req = 1'b0; b_req = 1'b0;
      #3;
      chk("t2_cnt", cnt0, 4);
      chk("t2_b_rvalid", b_rvalid_o[0], 1);
      chk("t2_b_rdata", b_rdata_o[0], 32'h66);
      tick();
      #3;
      chk("t2_a_rvalid", a_rvalid_o[0], 1);
      chk("t2_a_rdata", a_rdata_o[0], 32'hA5);
      repeat (3) tick();

      // 3: write then read of the same address on consecutive cycles
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 8'h11;
      #3 chk("t3_a_gnt", a_gnt_o[0], 1);
      tick();
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
      #3 chk("t3_b_gnt", b_gnt_o[0], 1);
      tick();
      b_req = 1'b0;
      tick(); tick();
      #3;
      chk("t3_b_rvalid", b_rvalid_o[0], 1);
      chk("t3_b_rdata", b_rdata_o[0], 32'h11);
      tick(); tick();

      // 4: stall with both requesting, then release
      stall = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'h3F;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'h05;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk($sformatf("t4_a_gnt_%0d", i), a_gnt_o[0], 0);
         chk($sformatf("t4_b_gnt_%0d", i), b_gnt_o[0], 0);
         chk($sformatf("t4_mem_en_%0d", i), mem_en_o[0], 0);
         chk($sformatf("t4_cnt_%0d", i), cnt0, 4);
         tick();
      end
      stall = 1'b0;
      #3;
      chk("t4_rel_a_gnt", a_gnt_o[0], 1);
      chk("t4_rel_b_gnt", b_gnt_o[0], 0);
      tick();
      a_req = 1'b0; b_req = 1'b0;
      #3;
      chk("t4_cnt_after", cnt0, 5);
      chk("t4_mem_addr", mem_addr_o[0], 32'h3F);
      repeat (4) tick();

      // 5: reset one cycle after an A read grant
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
      #3 chk("t5_a_gnt", a_gnt_o[0], 1);
      tick();
      a_req = 1'b0;
      rst = 1'b1;
      #3;
      chk("t5_mem_en", mem_en_o[0], 0);
      chk("t5_mem_addr", mem_addr_o[0], 0);
      chk("t5_a_rdata", a_rdata_o[0], 0);
      chk("t5_cnt", cnt0, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #3 chk($sformatf("t5_no_rvalid_%0d", i), a_rvalid_o[0], 0);
         tick();
      end
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'h05;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'h06;
      #3;
      chk("t5_tie_a_gnt", a_gnt_o[0], 1);
      chk("t5_tie_b_gnt", b_gnt_o[0], 0);

      // 6: keep contending for 19 cycles in total; the 4-bit counter sticks at 15
      repeat (19) tick();
      a_req = 1'b0; b_req = 1'b0;
      #3;
      chk("t6_cnt4_sat", cnt1, 15);
      chk("t6_cnt16", cnt0, 19);
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
